// File: rtl/ram_port_ctrl.sv
// Load/store controller for block-RAM port A: alignment check, lane enables, load extraction/extension.
// Latency store 2 / load 3 / fault 1 cycle to rsp_valid; one request in flight, req_ready low until IDLE.
module ram_port_ctrl #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_fault,
  output logic                  ram_en,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_din,
  input  logic [31:0]           ram_dout
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD      = 3'd2,
    S_RD_DATA = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [31:0]             rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_fault_q, rsp_fault_d;
  logic                    ram_en_q, ram_en_d;
  logic [3:0]              ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
  logic [31:0]             ram_din_q, ram_din_d;
  logic [1:0]              off_q, off_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;

  logic                    accept;
  logic                    fault;
  logic [31:0]             shifted;
  logic [31:0]             load_val;

  assign accept = req_valid && ready_q && (state_q == S_IDLE);
  assign fault  = (req_size == 2'b11) ||
                  ((req_size == 2'b01) && req_addr[0]) ||
                  ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (fault)          state_d = S_RESP;
          else if (req_write) state_d = S_WR;
          else                state_d = S_RD;
        end
      end
      S_WR:      state_d = S_RESP;
      S_RD:      state_d = S_RD_DATA;
      S_RD_DATA: state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Load lane extraction uses the offset/size captured at accept, since req_* is stale by now.
  always_comb begin
    shifted = ram_dout;
    if (size_q == 2'b00)      shifted = ram_dout >> {off_q, 3'b000};
    else if (size_q == 2'b01) shifted = ram_dout >> {off_q[1], 4'b0000};
    case (size_q)
      2'b00:   load_val = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  // Output values are computed for the next cycle and registered, so every output is a flop.
  always_comb begin
    ready_d     = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    rsp_rdata_d = 32'd0;
    rsp_fault_d = 1'b0;
    ram_en_d    = 1'b0;
    ram_we_d    = 4'b0000;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          off_d  = req_addr[1:0];
          size_d = req_size;
          uns_d  = req_unsigned;
          if (fault) begin
            rsp_fault_d = 1'b1;
          end else begin
            ram_en_d   = 1'b1;
            ram_addr_d = req_addr[ADDR_WIDTH+1:2];
            if (req_write) begin
              case (req_size)
                2'b00: begin
                  ram_we_d  = 4'b0001 << req_addr[1:0];
                  ram_din_d = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                  ram_we_d  = req_addr[1] ? 4'b1100 : 4'b0011;
                  ram_din_d = {2{req_wdata[15:0]}};
                end
                default: begin
                  ram_we_d  = 4'b1111;
                  ram_din_d = req_wdata;
                end
              endcase
            end
          end
        end
      end
      S_RD_DATA: rsp_rdata_d = load_val;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_fault_q <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 4'b0000;
      ram_addr_q  <= '0;
      ram_din_q   <= 32'd0;
      off_q       <= 2'b00;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
    end else begin
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Directed bench for ram_port_ctrl with a behavioural port-A RAM (registered read, read updates only when no lane written).
module tb_ram_port_ctrl;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW+1:0] req_addr = '0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [31:0]   req_wdata = 32'd0;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_fault;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout;

  int errs = 0;
  int checks = 0;

  logic [31:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  ram_port_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = 32'd0;
    ram_dout = 32'd0;
  end

  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      if (ram_we == 4'b0000) ram_dout <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one request from a negedge; reports latency (cycles after accept) and cycle-k+1 RAM drive.
  task automatic txn(input logic w, input logic [13:0] a, input logic [1:0] s, input logic u,
                     input logic [31:0] wd, output int lat, output logic [31:0] rd,
                     output logic flt, output logic en1, output logic [3:0] we1,
                     output logic [11:0] ad1, output logic [31:0] din1, output logic ram_act,
                     output logic rdy1);
    int n;
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    lat = 0; rd = 32'hx; flt = 1'bx; ram_act = 1'b0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = s;
    req_unsigned = u; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = 32'hA5A5A5A5;
    en1 = ram_en; we1 = ram_we; ad1 = ram_addr; din1 = ram_din; rdy1 = req_ready;
    for (int i = 1; i <= 6; i++) begin
      if (ram_en || (ram_we != 4'b0000)) ram_act = 1'b1;
      if (rsp_valid) begin
        lat = i; rd = rsp_rdata; flt = rsp_fault;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  int          lat;
  logic [31:0] rd, din1;
  logic        flt, en1, act, rdy1;
  logic [3:0]  we1;
  logic [11:0] ad1;
  int          seen;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_fault", {31'd0, rsp_fault}, 32'd0);
    chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("rst_ram_we", {28'd0, ram_we}, 32'd0);
    chk("rst_ram_addr", {20'd0, ram_addr}, 32'd0);
    chk("rst_ram_din", ram_din, 32'd0);
    rst_n = 1'b1;
    chk("rel_ready_low", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("rel_ready_high", {31'd0, req_ready}, 32'd1);

    // word store then load
    txn(1'b1, 14'h010, 2'b10, 1'b0, 32'hDEADBEEF, lat, rd, flt, en1, we1, ad1, din1, act, rdy1);
    chk("sw_lat", lat, 2);
    chk("sw_ready_drop", {31'd0, rdy1}, 32'd0);
    chk("sw_en", {31'd0, en1}, 32'd1);
    chk("sw_we", {28'd0, we1}, 32'hF);
    chk("sw_addr", {20'd0, ad1}, 32'd4);
    chk("sw_din", din1, 32'hDEADBEEF);
    chk("sw_rdata", rd, 32'd0);
    chk("sw_fault", {31'd0, flt}, 32'd0);
    txn(1'b0, 14'h010, 2'b10, 1'b0, 32'h0, lat, rd, flt, en1, we1, ad1, din1, act, rdy1);
    chk("lw_lat", lat, 3);
    chk("lw_en", {31'd0, en1}, 32'd1);
    chk("lw_we", {28'd0, we1}, 32'h0);
    chk("lw_addr", {20'd0, ad1}, 32'd4);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_fault", {31'd0, flt}, 32'd0);

    // byte lanes: word 4 becomes 0x80ADBEEF
    txn(1'b1, 14'h013, 2'b00, 1'b0, 32'h12345680, lat, rd, flt, en1, we1, ad1, din1, act, rdy1);
    chk("sb_lat", lat, 2);
    chk("sb_we", {28'd0, we1}, 32'h8);
    chk("sb_din", din1, 32'h80808080);
    txn(1'b0, 14'h013, 2'b00, 1'b0, 32'h0, lat, rd, flt, en1, we1, ad1, din1, act, rdy1);
    chk("lb_s_lat", lat, 3);
    chk("lb_s_rdata", rd, 32'hFFFFFF80);
    txn(1'b0, 14'h013, 2'b00, 1'b1, 32'h0, lat, rd, flt, en1, we1, ad1, din1, act, rdy1);
    chk("lb_u_rdata", rd, 32'h00000080);
    txn(1'b0, 14'h011, 2'b00, 1'b0, 32'h0, lat, rd, flt, en1, we1, ad1, din1, act, rdy1);
    chk("lb_s_off1", rd, 32'hFFFFFFBE);
    txn(1'b0, 14'h010, 2'b01, 1'b0, 32'h0, lat, rd, flt, en1, we1, ad1, din1, act, rdy1);
    chk("lh_s_lo", rd, 32'hFFFFBEEF);

    // half
    txn(1'b1, 14'h022, 2'b01, 1'b0, 32'hCAFE8001, lat, rd, flt, en1, we1, ad1, din1, act, rdy1);
    chk("sh_we", {28'd0, we1}, 32'hC);
    chk("sh_addr", {20'd0, ad1}, 32'd8);
    chk("sh_din", din1, 32'h80018001);
    txn(1'b0, 14'h022, 2'b01, 1'b0, 32'h0, lat, rd, flt, en1, we1, ad1, din1, act, rdy1);
    chk("lh_s_rdata", rd, 32'hFFFF8001);
    txn(1'b0, 14'h022, 2'b01, 1'b1, 32'h0, lat, rd, flt, en1, we1, ad1, din1, act, rdy1);
    chk("lh_u_rdata", rd, 32'h00008001);
    txn(1'b0, 14'h020, 2'b10, 1'b0, 32'h0, lat, rd, flt, en1, we1, ad1, din1, act, rdy1);
    chk("lw_half_word", rd, 32'h80010000);

    // faults
    txn(1'b0, 14'h001, 2'b10, 1'b0, 32'h0, lat, rd, flt, en1, we1, ad1, din1, act, rdy1);
    chk("f_lw_lat", lat, 1);
    chk("f_lw_fault", {31'd0, flt}, 32'd1);
    chk("f_lw_rdata", rd, 32'd0);
    chk("f_lw_ram", {31'd0, act}, 32'd0);
    txn(1'b1, 14'h003, 2'b01, 1'b0, 32'h00001234, lat, rd, flt, en1, we1, ad1, din1, act, rdy1);
    chk("f_sh_lat", lat, 1);
    chk("f_sh_fault", {31'd0, flt}, 32'd1);
    chk("f_sh_ram", {31'd0, act}, 32'd0);
    txn(1'b1, 14'h010, 2'b11, 1'b0, 32'h11111111, lat, rd, flt, en1, we1, ad1, din1, act, rdy1);
    chk("f_sz_lat", lat, 1);
    chk("f_sz_fault", {31'd0, flt}, 32'd1);
    chk("f_sz_ram", {31'd0, act}, 32'd0);
    txn(1'b0, 14'h000, 2'b10, 1'b0, 32'h0, lat, rd, flt, en1, we1, ad1, din1, act, rdy1);
    chk("f_rb_word0", rd, 32'd0);
    txn(1'b0, 14'h010, 2'b10, 1'b0, 32'h0, lat, rd, flt, en1, we1, ad1, din1, act, rdy1);
    chk("f_rb_word4", rd, 32'h80ADBEEF);

    // reset during RD_DATA drops the load
    req_valid = 1'b1; req_write = 1'b0; req_addr = 14'h010; req_size = 2'b10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid) seen++;
      @(negedge clk);
    end
    chk("rst_mid_no_rsp", seen, 0);
    txn(1'b0, 14'h010, 2'b10, 1'b0, 32'h0, lat, rd, flt, en1, we1, ad1, din1, act, rdy1);
    chk("rst_mid_lat", lat, 3);
    chk("rst_mid_rdata", rd, 32'h80ADBEEF);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ram_port_ctrl.md
# ram_port_ctrl

Load/store access controller that sits directly upstream of the dual-port block RAM's read/write port (port A). It accepts one CPU data-memory request at a time (byte/half/word, signed or unsigned loads), checks alignment, and drives registered RAM address, byte-lane write enables and lane-replicated write data. For loads it waits out the RAM's one-cycle registered read, then extracts, sign- or zero-extends and returns the data with a single-cycle response pulse.

## Interface
Parameters:
- ADDR_WIDTH, 12, RAM word-address width (RAM depth 2**ADDR_WIDTH words of 32 bits)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, also drives RAM port A
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; request accepted when req_valid && req_ready at posedge clk
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH+2  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 zero-extend, 0 sign-extend
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_rdata  out  32  extended load data (0 for stores and faults)
- rsp_fault  out  1  qualified by rsp_valid: misaligned or illegal size
- ram_en  out  1  RAM port enable
- ram_we  out  4  RAM byte write enables
- ram_addr  out  ADDR_WIDTH  RAM word address
- ram_din  out  32  RAM write data
- ram_dout  in  32  RAM read data, valid the cycle after the address cycle

## Operation
- States: IDLE, WR, RD, RD_DATA, RESP. All outputs registered.
- IDLE: req_ready=1. On accept, capture addr[1:0], size, unsigned flag; req_ready drops next cycle.
- Fault check at accept: size 11, half with addr[0]=1, or word with addr[1:0]!=0 -> RESP with rsp_fault=1, rsp_rdata=0; no RAM activity (ram_en=0, ram_we=0).
- Store -> WR: ram_en=1, ram_addr=req_addr[ADDR_WIDTH+1:2], ram_we/ram_din:
  - byte: ram_we=0001<<addr[1:0], ram_din={4{wdata[7:0]}}
  - half: ram_we=0011 (addr[1]=0) or 1100 (addr[1]=1), ram_din={2{wdata[15:0]}}
  - word: ram_we=1111, ram_din=wdata
  - Only these seven masks are ever produced; the RAM ignores any other pattern.
  - Then -> RESP, rsp_rdata=0, rsp_fault=0.
- Load -> RD: ram_en=1, ram_we=0000 (mandatory: the RAM updates its read output only when no lane is written), ram_addr set. -> RD_DATA.
- RD_DATA: ram_en=0. Sample ram_dout, shift right by 8*addr[1:0] (byte) or 16*addr[1] (half), extend per req_unsigned, register into rsp_rdata. -> RESP.
- RESP: rsp_valid=1 for exactly one cycle. req_ready is set at the end of RESP; -> IDLE.
- ram_we is nonzero only in WR; ram_en is high only in WR and RD.
- req_* inputs are ignored outside the accept cycle.

## Timing
- Accept at edge k. Store: WR in cycle k+1, rsp_valid in cycle k+2. Load: RD k+1, RD_DATA k+2, rsp_valid k+3. Fault: rsp_valid k+1.
- Next accept is possible at the edge ending RESP+1, i.e. IDLE lasts at least one cycle. Throughput: 1 store per 3 cycles, 1 load per 4 cycles.
- Reset (async, rst_n low): state=IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_fault=0, ram_en=0, ram_we=0, ram_addr=0, ram_din=0. req_ready rises at the first posedge after rst_n deasserts.
- Reset during WR: ram_we clears immediately; the RAM write happens only if a clock edge already occurred in WR. Any in-flight request is dropped; no response is issued.
- Store followed by a load to the same word returns the new data, because RAM write and read use separate cycles.

## Test plan
- Reset: hold rst_n=0 for 3 cycles -> all outputs 0; req_ready=1 one cycle after release.
- Word store/load: store 0xDEADBEEF at addr 0x010, then load word at 0x010 -> ram_we=1111, ram_addr=4; rsp_rdata=0xDEADBEEF at k+3.
- Byte lanes: store byte 0x80 at 0x013 -> ram_we=1000, ram_din=0x80808080. Signed byte load at 0x013 -> 0xFFFFFF80; unsigned -> 0x00000080.
- Half: store 0x8001 at 0x022 -> ram_we=1100. Signed half load at 0x022 -> 0xFFFF8001; unsigned -> 0x00008001.
- Faults: word load at 0x001, half store at 0x003, size 11 -> rsp_fault=1 and rsp_valid at k+1; ram_en and ram_we stay 0; memory unchanged on readback.
- Reset mid-load: assert rst_n low during RD_DATA -> no rsp_valid; after release, a word load at 0x010 returns the previously stored data.
